// File: rtl/fib_pair_serializer.sv
// fib_pair_serializer: buffers {a, b} number pairs in a small circular
// store and emits them one word at a time, a first, then b.
// Each pair occupies one entry. A half-select bit tracks which word of the
// head entry is currently on out_data.
module fib_pair_serializer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_second,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Which word of the head entry is being presented.
  typedef enum logic {
    HALF_A = 1'b0,
    HALF_B = 1'b1
  } half_t;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  half_t         half;

  logic push;
  logic xfer;
  logic pop;

  // Full-buffer push-through is not supported, so in_ready depends only on
  // the stored level; it is forced low during reset.
  assign in_ready   = (level < LW'(DEPTH)) && !rst;
  assign out_valid  = (level != '0);
  assign push       = in_valid && in_ready;
  assign xfer       = out_valid && out_ready;
  // An entry leaves the store only once its second word has been taken.
  assign pop        = xfer && (half == HALF_B);

  assign out_second = (half == HALF_B);
  assign out_data   = (half == HALF_B) ? mem_b[rd_ptr] : mem_a[rd_ptr];

  // Pair storage: written on push.
  // NOTE: the storage array has no reset; stale entries are never visible
  // because out_valid is low whenever level is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // Pointer, level and half-select control; reset discards all contents.
  // NOTE: every sequential assignment is non-blocking so that all reads in
  // this block see the pre-edge values of level, half and the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      half   <= HALF_A;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      if (xfer) half <= (half == HALF_A) ? HALF_B : HALF_A;

      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_pair_serializer.sv
// tb_fib_pair_serializer: directed and random stimulus for
// fib_pair_serializer, checked against a word-queue reference model.
// The model holds the flattened output word stream; level is derived as the
// number of pairs that still have at least one word pending.
module tb_fib_pair_serializer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_second;
  logic [$clog2(DEPTH):0] level;

  fib_pair_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_second (out_second),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending output words, {is_second, data}.
  logic [WIDTH:0] words [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by whatever transfers the model predicts.
  task automatic step(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic ordy, output logic accepted);
    int  n;
    int  exp_lvl;
    logic exp_ov;
    logic exp_ir;
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    n       = words.size();
    exp_lvl = (n + 1) / 2;
    exp_ov  = (n != 0);
    exp_ir  = (exp_lvl < DEPTH);
    check("level", 32'(level), 32'(exp_lvl));
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("out_second", 32'(out_second), exp_ov ? 32'(words[0][WIDTH]) : 32'd0);
    if (exp_ov) check("out_data", 32'(out_data), 32'(words[0][WIDTH-1:0]));
    accepted = iv && exp_ir;
    @(posedge clk);
    if (exp_ov && ordy) void'(words.pop_front());
    if (accepted) begin
      words.push_back({1'b0, a});
      words.push_back({1'b1, b});
    end
  endtask

  // One reset cycle with traffic offered on both sides; reset must win.
  task automatic reset_cycle();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_a      = 16'hdead;
    in_b      = 16'hbeef;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    words.delete();
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 40 && words.size() != 0; i++) step(1'b0, '0, '0, 1'b1, acc);
    check("drain_empty", 32'(words.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   idx;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    reset_cycle();
    reset_cycle();

    // Reset state, then back-to-back pushes streamed out one word per cycle.
    step(1'b1, 16'd1, 16'd1, 1'b1, acc);
    check("push1_accepted", 32'(acc), 32'd1);
    step(1'b1, 16'd2, 16'd3, 1'b1, acc);
    step(1'b1, 16'd5, 16'd8, 1'b1, acc);
    drain();

    // Fill with out_ready low; the fifth pair waits for the first pop.
    step(1'b1, 16'd1,  16'd1,  1'b0, acc);
    step(1'b1, 16'd2,  16'd3,  1'b0, acc);
    step(1'b1, 16'd5,  16'd8,  1'b0, acc);
    step(1'b1, 16'd13, 16'd21, 1'b0, acc);
    step(1'b1, 16'd34, 16'd55, 1'b0, acc);
    check("full_holdoff", 32'(acc), 32'd0);
    step(1'b1, 16'd34, 16'd55, 1'b1, acc);
    check("full_first_word", 32'(acc), 32'd0);
    step(1'b1, 16'd34, 16'd55, 1'b1, acc);
    check("full_pop_then_push", 32'(acc), 32'd0);
    step(1'b1, 16'd34, 16'd55, 1'b1, acc);
    check("full_push_after_pop", 32'(acc), 32'd1);
    drain();

    // Stall on the second word of a pair for five cycles.
    step(1'b1, 16'd34, 16'd55, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, acc);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, acc);
    check("stall_done", 32'(words.size()), 32'd0);

    // Random stream of ten pairs with random backpressure on both sides.
    idx = 0;
    ra  = 16'($urandom);
    rb  = 16'($urandom);
    for (int c = 0; c < 300 && idx < 10; c++) begin
      step(($urandom % 4) != 0, ra, rb, 1'($urandom_range(0, 1)), acc);
      if (acc) begin
        idx++;
        ra = 16'($urandom);
        rb = 16'($urandom);
      end
    end
    check("stream_pushed", 32'(idx), 32'd10);
    drain();

    // Reset with three pairs stored and the head half-emitted.
    step(1'b1, 16'd1, 16'd1, 1'b0, acc);
    step(1'b1, 16'd2, 16'd3, 1'b0, acc);
    step(1'b1, 16'd5, 16'd8, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, acc);
    check("pre_reset_second", 32'(words[0][WIDTH]), 32'd1);
    reset_cycle();
    step(1'b1, 16'd89, 16'd144, 1'b1, acc);
    check("post_reset_push", 32'(acc), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
